// File: rtl/win_score_tracker.sv
// Purpose : per-player win counter with seven-segment digits, playfield reset pulse and match-over latch.
// Latency : 1 cycle from a qualifying rising edge to Hex/ResetGame/GameOver/Winner; every output is registered.
// Backpr. : none; credits that arrive during the reset pulse or after the match is decided are dropped.
//
// Ports:
//   Clock     - system clock, single domain
//   Reset     - synchronous, active-high; returns everything to the power-on picture
//   Button    - debounced action button, gates every player's win indicator
//   WinEvent  - per-player win indicator, bit i = player i
//   Hex       - active-low gfedcba segments, player i on bits [7i+6:7i]
//   ResetGame - playfield reset, high for RESET_PULSE cycles after each non-final win
//   GameOver  - high once some player reaches WIN_TARGET; held until Reset
//   Winner    - index of the winning player, meaningful while GameOver=1
module win_score_tracker #(
  parameter int NUM_PLAYERS = 2,
  parameter int WIN_TARGET  = 7,
  parameter int RESET_PULSE = 4,
  localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Button,
  input  logic [NUM_PLAYERS-1:0]     WinEvent,
  output logic [7*NUM_PLAYERS-1:0]   Hex,
  output logic                       ResetGame,
  output logic                       GameOver,
  output logic [WW-1:0]              Winner
);

  // Pulse counter only has to hold RESET_PULSE-1.
  localparam int CW = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
  localparam logic [3:0]    TARGET     = 4'(WIN_TARGET);
  localparam logic [CW-1:0] PULSE_LAST = CW'(RESET_PULSE - 1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PULSE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          pulse_cnt;
  logic [NUM_PLAYERS-1:0] qual;
  logic [NUM_PLAYERS-1:0] hist;
  logic [NUM_PLAYERS-1:0] rise;
  logic [3:0]             score [NUM_PLAYERS];

  logic                   credit_vld;
  logic [WW-1:0]          credit_idx;
  logic [3:0]             credit_score;

  // Active-low gfedcba encoding for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign qual = WinEvent & {NUM_PLAYERS{Button}};
  // hist resets to all ones, so a qualifier held through reset release
  // must drop and rise again before it can score.
  assign rise = qual & ~hist;

  // Lowest-index rising edge takes the credit. The loop walks downward so the
  // last assignment is the lowest set bit; the other edges are simply lost.
  always_comb begin
    credit_vld   = 1'b0;
    credit_idx   = '0;
    credit_score = 4'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (rise[i]) begin
        credit_vld   = 1'b1;
        credit_idx   = WW'(i);
        credit_score = score[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= PLAY;
      pulse_cnt <= '0;
      hist      <= '1;
      ResetGame <= 1'b0;
      GameOver  <= 1'b0;
      Winner    <= '0;
      Hex       <= {NUM_PLAYERS{7'b1000000}};
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score[i] <= 4'd0;
      end
    end else begin
      // Edge history tracks the qualifiers in every state, so a qualifier
      // held across a pulse cannot produce a second credit afterwards.
      hist <= qual;

      case (state)
        PLAY: begin
          if (credit_vld) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (WW'(i) == credit_idx) begin
                score[i]      <= credit_score;
                Hex[7*i +: 7] <= seg7(credit_score);
              end
            end
            if (credit_score == TARGET) begin
              // Final win: latch the result, no playfield pulse.
              state    <= DONE;
              GameOver <= 1'b1;
              Winner   <= credit_idx;
            end else begin
              // ResetGame goes high on this edge and stays for RESET_PULSE
              // cycles; the counter counts the remaining high edges.
              state     <= PULSE;
              ResetGame <= 1'b1;
              pulse_cnt <= PULSE_LAST;
            end
          end
        end

        PULSE: begin
          if (pulse_cnt == '0) begin
            state     <= PLAY;
            ResetGame <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - CW'(1);
          end
        end

        DONE: begin
          // Terminal until Reset; scores, Winner and GameOver stay frozen.
        end

        default: begin
          state     <= PLAY;
          ResetGame <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/win_score_tracker.md
# win_score_tracker

Multi-player, parametrised round/score tracker for the game cores. It counts qualified wins per player and drives one active-low seven-segment digit per player. After each non-final win it pulses a game-reset for a configurable number of cycles. When any player reaches the target it latches game-over and the winner index. It sits between the game logic (win indicators, pushbutton) and the HEX displays, and feeds the playfield reset.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players/digits (1..4)
- WIN_TARGET, 7, wins needed to end the match (1..9)
- RESET_PULSE, 4, ResetGame high time in cycles (>=1)

Ports (WW = max(1, $clog2(NUM_PLAYERS))):
- Clock  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high; clears all state
- Button  in  1  player action button, already synchronised/debounced
- WinEvent  in  NUM_PLAYERS  per-player win indicator (bit i = player i)
- Hex  out  7*NUM_PLAYERS  active-low segments gfedcba; player i on bits [7i+6:7i]
- ResetGame  out  1  playfield reset pulse
- GameOver  out  1  high once the match is decided
- Winner  out  WW  index of winning player; valid while GameOver=1

## Operation
- Qualifier q[i] = Button & WinEvent[i].
- Credit for player i occurs only on a rising edge of q[i]: q[i]=1 this cycle and 0 on the previous sampled cycle.
- The edge-history register updates every cycle in all states.
- At most one credit per cycle. On simultaneous edges the lowest index wins and the other edges are discarded, not deferred.
- States:
  - PLAY: accepts credits. A credit with new score < WIN_TARGET goes to PULSE. A credit with new score == WIN_TARGET goes to DONE.
  - PULSE: ResetGame=1 for exactly RESET_PULSE cycles, then returns to PLAY. Credits are ignored here, but edge history still tracks.
  - DONE: terminal until Reset. GameOver=1 and Winner holds. ResetGame stays 0 (no pulse on the final win). Scores are frozen.
- Score registers are 4 bits per player, range 0..WIN_TARGET, and never wrap.
- Digit encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset values:
  - State: PLAY.
  - All scores: 0, so every digit shows 1000000.
  - ResetGame, GameOver, Winner: 0.
  - Edge-history bits: all 1. A qualifier held through reset release does not credit until it drops and rises again.
- Reset asserted mid-PULSE or in DONE: the next cycle shows full reset values, and ResetGame drops immediately.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Credit sampled at posedge N gives the following at posedge N:
  - The score, and therefore Hex, updates.
  - ResetGame rises, or GameOver/Winner rise for the final win.
- ResetGame is high for cycles N..N+RESET_PULSE-1 (edges N through N+RESET_PULSE-1).
- The state is back in PLAY after edge N+RESET_PULSE. The earliest next credit is sampled at edge N+RESET_PULSE+1.
- Latency from qualifying edge to display: 1 cycle.
- If q[i] stays high through the whole pulse, it yields no second credit.

## Test plan
- Reset hold 3 cycles with Button=1, WinEvent=01 -> Hex all 1000000, ResetGame=0, no credit after release until q drops and rises.
- Defaults. Five separated Button pulses with WinEvent=01 -> player0 digit walks 1111001, 0100100, 0110000, 0011001, 0010010. Each credit gives ResetGame high exactly 4 cycles. Player1 digit stays 1000000.
- Simultaneous edges with WinEvent=11 and Button rising -> only player0 increments, player1 unchanged.
- Qualifier held high across the entire pulse and 10 further cycles -> exactly one credit.
- WIN_TARGET=3. Player1 gets 3 credits -> after the third, GameOver=1, Winner=1, ResetGame stays 0, Hex player1=0110000. Further Button/WinEvent activity changes nothing.
- Reset asserted on the 2nd cycle of a pulse -> next cycle ResetGame=0, scores 0, state PLAY. Reset asserted in DONE -> GameOver=0, Winner=0.
